loadstore_unit: RTL and testbench
=================================

Name: loadstore_unit

Overview:
- Back end of the execute-stage load/store interface.
- Consumes execute's memory request (`port_a`, `port_b`, `store_data`, `load_type`, `dren`, `dwen`, `wen`, `reg_rd`) and runs one access on the data-memory generic bus.
- Returns the formatted load result with `wen` and `reg_rd` for register writeback.
- Stalls execute through `busy` while an access is in flight; flags misaligned accesses instead of issuing them.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into the `fault_pc` register on reset.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- port_a  input  32  base operand (rs1)
- port_b  input  32  offset operand (immediate)
- store_data  input  32  rs2 value for stores
- pc  input  32  PC of the requesting instruction
- load_type  input  3  funct3 width code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
- dren  input  1  load request
- dwen  input  1  store request
- wen  input  1  instruction writes rd
- reg_rd  input  5  destination register
- wdata_ls  output  32  formatted load data
- wen_out  output  1  writeback strobe, one cycle
- reg_rd_out  output  5  writeback destination
- busy  output  1  stall execute; request inputs are held stable while high
- misaligned  output  1  one-cycle fault pulse
- fault_addr  output  32  faulting effective address
- fault_pc  output  32  faulting PC
- dmem_addr  output  32  word-aligned bus address
- dmem_wdata  output  32  store data, lane-replicated
- dmem_byte_en  output  4  byte lane enables
- dmem_ren  output  1  bus read request
- dmem_wen  output  1  bus write request
- dmem_rdata  input  32  bus read data, valid when `dmem_busy` is low
- dmem_busy  input  1  bus not yet complete

Behaviour:
- Effective address: `ea = port_a + port_b`, modulo 2^32.
- Misaligned condition:
  - halfword with `ea[0]` set, or
  - word with `ea[1:0]` nonzero.
- Undefined codes 011, 110 and 111 are treated as word, signed.
- If `dren` and `dwen` are both set, the request is a load; the store is dropped.
- States and transitions:
  - IDLE: on `dren` or `dwen`:
    - Misaligned: register `misaligned`=1, `fault_addr`=`ea`, `fault_pc`=`pc` for exactly one cycle; no bus access; stay in IDLE.
    - Otherwise: latch `ea`, `store_data`, `load_type`, direction, `wen` and `reg_rd`; go to ACCESS.
  - ACCESS: drive `dmem_ren` or `dmem_wen` continuously until a cycle with `dmem_busy`=0.
    - In that cycle, register the formatted `dmem_rdata` for loads.
    - Next state is WB.
  - WB: pulse `wen_out` for one cycle.
    - `wen_out` = load && latched `wen` && latched `reg_rd` != 0.
    - A new request present in WB is evaluated exactly as in IDLE, giving back-to-back accesses with no idle bubble.
    - Otherwise return to IDLE.
- `busy` is combinational:
  - high for a non-misaligned request in IDLE or WB;
  - high throughout ACCESS;
  - low in every other case.
- Latency: request accepted at cycle 0; bus asserted from cycle 1; bus completes at cycle N; `wen_out` at N+1, where `busy` is already low.
- Bus addressing: `dmem_addr` = {`ea[31:2]`, 2'b00}.
- Byte enables (little-endian):
  - byte: 1 << `ea[1:0]`
  - half: 0011 or 1100 selected by `ea[1]`
  - word: 1111
- Store data replication: byte {4{sd[7:0]}}, half {2{sd[15:0]}}, word sd.
- Load formatting: select the addressed lane, then sign-extend for 000/001 or zero-extend for 100/101.
- Hold behaviour: `wdata_ls` and `reg_rd_out` hold their last values; only `wen_out` pulses.
- Reset: asynchronous and dominant, including in the middle of an access.
  - State returns to IDLE.
  - Bus requests drop immediately.
  - All outputs go to 0, except `fault_pc`, which resets to RESET_PC.

Test Plan:
1. LW with `port_a`=0x1000, `port_b`=4, `dmem_busy` high for 2 cycles, `dmem_rdata`=0xDEADBEEF, rd=5 -> `dmem_addr`=0x1004, `byte_en`=1111, `ren` held 3 cycles, then `wen_out`=1, `wdata_ls`=0xDEADBEEF, `reg_rd_out`=5; `busy` low in the WB cycle.
2. LB/LBU at `ea`=0x2003 with `rdata`=0x80FF_FF7F -> `byte_en`=1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
3. SH at `ea`=0x3002 with `store_data`=0x1234ABCD -> `byte_en`=1100, `dmem_wdata`=0xABCDABCD, `dmem_wen` asserted, no `wen_out`.
4. LW at `ea`=0x4001, `pc`=0x80 -> no `ren`/`wen`; `misaligned`=1 for one cycle, `fault_addr`=0x4001, `fault_pc`=0x80; `busy` stays 0.
5. Back-to-back LW then SW with zero-wait bus -> second access issued the cycle after the first WB with no IDLE bubble; LW to rd=0 gives `wen_out`=0.
6. nRST asserted while `dmem_ren` is high in ACCESS -> `ren`, `busy` and `wen_out` drop asynchronously; after release the next request runs cleanly from IDLE.

Source files
------------

// File: rtl/loadstore_unit.sv
// loadstore_unit: back end of the execute-stage load/store path.
// Takes one memory request from execute, runs it on the data-memory bus,
// and returns formatted load data for register writeback.
// Ports:
//   CLK, nRST                     clock, async active-low reset
//   port_a/port_b/store_data/pc   operands, store value, requesting PC
//   load_type, dren, dwen         access width code and direction
//   wen, reg_rd                   writeback enable / destination in
//   wdata_ls, wen_out, reg_rd_out writeback data / strobe / destination out
//   busy                          stall to execute
//   misaligned, fault_addr/pc     misalignment pulse and fault record
//   dmem_*                        generic data-memory bus
//
// state  | meaning
// IDLE   | no access in flight, evaluating requests
// ACCESS | bus request held until dmem_busy drops
// WB     | writeback pulse; a new request may be accepted here
module loadstore_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] port_a,
    input  logic [31:0] port_b,
    input  logic [31:0] store_data,
    input  logic [31:0] pc,
    input  logic [2:0]  load_type,
    input  logic        dren,
    input  logic        dwen,
    input  logic        wen,
    input  logic [4:0]  reg_rd,
    output logic [31:0] wdata_ls,
    output logic        wen_out,
    output logic [4:0]  reg_rd_out,
    output logic        busy,
    output logic        misaligned,
    output logic [31:0] fault_addr,
    output logic [31:0] fault_pc,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_en,
    output logic        dmem_ren,
    output logic        dmem_wen,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WB} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, sdata_q, wdata_q, fault_addr_q, fault_pc_q;
    logic [2:0]  type_q;
    logic        load_q, wen_q, mis_q;
    logic [4:0]  rd_q, rd_out_q;

    logic [31:0] ea, lane, fmt;
    logic        req, mis, in_slot, accept, fault, done;

    // Width from load_type[1:0]: 00 byte, 01 half, 1x word (covers the
    // undefined codes). Zero-extension only for 100/101.
    assign ea      = port_a + port_b;
    assign req     = dren | dwen;
    assign mis     = ((load_type[1:0] == 2'b01) && ea[0]) ||
                     (load_type[1] && (ea[1:0] != 2'b00));
    assign in_slot = (state_q == S_IDLE) || (state_q == S_WB);
    // Gated by nRST so execute sees no stall while the unit is held in reset.
    assign accept  = nRST && in_slot && req && !mis;
    assign fault   = in_slot && req && mis;
    assign done    = (state_q == S_ACCESS) && !dmem_busy;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_ACCESS;
            S_ACCESS: if (!dmem_busy) state_d = S_WB;
            S_WB:     state_d = accept ? S_ACCESS : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = accept || (state_q == S_ACCESS);
        dmem_ren = (state_q == S_ACCESS) && load_q;
        dmem_wen = (state_q == S_ACCESS) && !load_q;
        wen_out  = (state_q == S_WB) && load_q && wen_q && (rd_q != 5'd0);
    end

    // Aligned accesses: shifting by the byte offset lands the lane at bit 0.
    assign lane = dmem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        fmt          = lane;
        dmem_byte_en = 4'b0000;
        dmem_wdata   = 32'd0;
        case (type_q[1:0])
            2'b00:   fmt = {{24{!type_q[2] && lane[7]}}, lane[7:0]};
            2'b01:   fmt = {{16{!type_q[2] && lane[15]}}, lane[15:0]};
            default: fmt = lane;
        endcase
        if (state_q == S_ACCESS) begin
            case (type_q[1:0])
                2'b00: begin
                    dmem_byte_en = 4'b0001 << addr_q[1:0];
                    dmem_wdata   = {4{sdata_q[7:0]}};
                end
                2'b01: begin
                    dmem_byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
                    dmem_wdata   = {2{sdata_q[15:0]}};
                end
                default: begin
                    dmem_byte_en = 4'b1111;
                    dmem_wdata   = sdata_q;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q       <= 32'd0;
            sdata_q      <= 32'd0;
            type_q       <= 3'd0;
            load_q       <= 1'b0;
            wen_q        <= 1'b0;
            rd_q         <= 5'd0;
            wdata_q      <= 32'd0;
            rd_out_q     <= 5'd0;
            mis_q        <= 1'b0;
            fault_addr_q <= 32'd0;
            fault_pc_q   <= RESET_PC;
        end else begin
            if (accept) begin
                addr_q  <= ea;
                sdata_q <= store_data;
                type_q  <= load_type;
                load_q  <= dren;   // dren wins when both are set
                wen_q   <= wen;
                rd_q    <= reg_rd;
            end
            if (done && load_q) begin
                wdata_q  <= fmt;
                rd_out_q <= rd_q;
            end
            mis_q <= fault;
            if (fault) begin
                fault_addr_q <= ea;
                fault_pc_q   <= pc;
            end
        end
    end

    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign wdata_ls   = wdata_q;
    assign reg_rd_out = rd_out_q;
    assign misaligned = mis_q;
    assign fault_addr = fault_addr_q;
    assign fault_pc   = fault_pc_q;

endmodule

// File: tb/tb_loadstore_unit.sv
module tb_loadstore_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] port_a, port_b, store_data, pc;
    logic [2:0]  load_type;
    logic        dren, dwen, wen;
    logic [4:0]  reg_rd;
    logic [31:0] wdata_ls;
    logic        wen_out;
    logic [4:0]  reg_rd_out;
    logic        busy, misaligned;
    logic [31:0] fault_addr, fault_pc, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_byte_en;
    logic        dmem_ren, dmem_wen;
    logic [31:0] dmem_rdata;
    logic        dmem_busy;

    int n_checks = 0;
    int n_errors = 0;
    int ren_cycles;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    loadstore_unit #(.RESET_PC(RST_PC)) dut (
        .CLK(CLK), .nRST(nRST),
        .port_a(port_a), .port_b(port_b), .store_data(store_data), .pc(pc),
        .load_type(load_type), .dren(dren), .dwen(dwen), .wen(wen), .reg_rd(reg_rd),
        .wdata_ls(wdata_ls), .wen_out(wen_out), .reg_rd_out(reg_rd_out),
        .busy(busy), .misaligned(misaligned),
        .fault_addr(fault_addr), .fault_pc(fault_pc),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
        .dmem_rdata(dmem_rdata), .dmem_busy(dmem_busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] lt,
                           input logic rd_en, input logic wr_en, input logic w, input logic [4:0] rd);
        port_a = a; port_b = b; load_type = lt;
        dren = rd_en; dwen = wr_en; wen = w; reg_rd = rd;
    endtask

    initial begin
        nRST = 1'b0;
        port_a = 0; port_b = 0; store_data = 0; pc = 0; load_type = 0;
        dren = 0; dwen = 0; wen = 0; reg_rd = 0;
        dmem_rdata = 0; dmem_busy = 0;
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ren", {31'd0, dmem_ren}, 32'd0);
        check_eq("rst_fault_pc", fault_pc, RST_PC);
        check_eq("rst_wdata", wdata_ls, 32'd0);
        check_eq("rst_addr", dmem_addr, 32'd0);
        check_eq("rst_be", {28'd0, dmem_byte_en}, 32'd0);
        nRST = 1'b1;
        step();

        // 1: LW 0x1004, bus busy for two cycles
        set_req(32'h1000, 32'h4, 3'b010, 1, 0, 1, 5'd5);
        dmem_busy = 1;
        #1;
        check_eq("t1_busy_idle", {31'd0, busy}, 32'd1);
        check_eq("t1_ren_idle", {31'd0, dmem_ren}, 32'd0);
        step();
        check_eq("t1_addr", dmem_addr, 32'h1004);
        check_eq("t1_be", {28'd0, dmem_byte_en}, 32'hF);
        ren_cycles = 0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) begin
                dmem_busy  = 0;
                dmem_rdata = 32'hDEADBEEF;
            end
            #1;
            if (dmem_ren) ren_cycles++;
            check_eq("t1_busy_access", {31'd0, busy}, 32'd1);
            step();
        end
        dren = 0;
        #1;
        check_eq("t1_ren_cycles", ren_cycles, 32'd3);
        check_eq("t1_wen_out", {31'd0, wen_out}, 32'd1);
        check_eq("t1_wdata", wdata_ls, 32'hDEADBEEF);
        check_eq("t1_rd_out", {27'd0, reg_rd_out}, 32'd5);
        check_eq("t1_busy_wb", {31'd0, busy}, 32'd0);
        step();
        check_eq("t1_wen_pulse", {31'd0, wen_out}, 32'd0);
        check_eq("t1_wdata_hold", wdata_ls, 32'hDEADBEEF);

        // 2: LB and LBU at 0x2003
        dmem_rdata = 32'h80FF_FF7F;
        set_req(32'h2000, 32'h3, 3'b000, 1, 0, 1, 5'd3);
        step();
        check_eq("t2_lb_be", {28'd0, dmem_byte_en}, 32'h8);
        step();
        dren = 0;
        #1;
        check_eq("t2_lb_data", wdata_ls, 32'hFFFFFF80);
        step();
        set_req(32'h2000, 32'h3, 3'b100, 1, 0, 1, 5'd3);
        step();
        check_eq("t2_lbu_be", {28'd0, dmem_byte_en}, 32'h8);
        step();
        dren = 0;
        #1;
        check_eq("t2_lbu_data", wdata_ls, 32'h00000080);
        step();

        // 3: SH at 0x3002
        store_data = 32'h1234ABCD;
        set_req(32'h3000, 32'h2, 3'b001, 0, 1, 0, 5'd0);
        step();
        check_eq("t3_wen", {31'd0, dmem_wen}, 32'd1);
        check_eq("t3_ren", {31'd0, dmem_ren}, 32'd0);
        check_eq("t3_be", {28'd0, dmem_byte_en}, 32'hC);
        check_eq("t3_wdata", dmem_wdata, 32'hABCDABCD);
        check_eq("t3_addr", dmem_addr, 32'h3000);
        step();
        dwen = 0;
        #1;
        check_eq("t3_wen_out", {31'd0, wen_out}, 32'd0);
        check_eq("t3_wdata_ls_hold", wdata_ls, 32'h00000080);
        step();

        // 4: misaligned LW at 0x4001
        pc = 32'h80;
        set_req(32'h4000, 32'h1, 3'b010, 1, 0, 1, 5'd4);
        #1;
        check_eq("t4_busy", {31'd0, busy}, 32'd0);
        step();
        dren = 0;
        #1;
        check_eq("t4_mis", {31'd0, misaligned}, 32'd1);
        check_eq("t4_faddr", fault_addr, 32'h4001);
        check_eq("t4_fpc", fault_pc, 32'h80);
        check_eq("t4_ren", {31'd0, dmem_ren}, 32'd0);
        step();
        check_eq("t4_mis_pulse", {31'd0, misaligned}, 32'd0);
        check_eq("t4_no_bus", {30'd0, dmem_ren, dmem_wen}, 32'd0);

        // 5: back-to-back LW (rd=0) then SW, zero-wait bus
        dmem_busy  = 0;
        dmem_rdata = 32'h11223344;
        set_req(32'h5000, 32'h8, 3'b010, 1, 0, 1, 5'd0);
        step();
        check_eq("t5_ren", {31'd0, dmem_ren}, 32'd1);
        step();
        store_data = 32'hCAFEF00D;
        set_req(32'h6000, 32'hC, 3'b010, 0, 1, 0, 5'd0);
        #1;
        check_eq("t5_wen_out_rd0", {31'd0, wen_out}, 32'd0);
        check_eq("t5_wdata", wdata_ls, 32'h11223344);
        check_eq("t5_busy_wb", {31'd0, busy}, 32'd1);
        step();
        check_eq("t5_sw_wen", {31'd0, dmem_wen}, 32'd1);
        check_eq("t5_sw_addr", dmem_addr, 32'h600C);
        check_eq("t5_sw_wdata", dmem_wdata, 32'hCAFEF00D);
        step();
        dwen = 0;
        #1;
        check_eq("t5_busy_after", {31'd0, busy}, 32'd0);
        step();

        // 6: reset in the middle of an access
        dmem_busy = 1;
        set_req(32'h7000, 32'h0, 3'b010, 1, 0, 1, 5'd7);
        step();
        check_eq("t6_ren_pre", {31'd0, dmem_ren}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        check_eq("t6_ren_rst", {31'd0, dmem_ren}, 32'd0);
        check_eq("t6_busy_rst", {31'd0, busy}, 32'd0);
        check_eq("t6_wen_out_rst", {31'd0, wen_out}, 32'd0);
        check_eq("t6_fpc_rst", fault_pc, RST_PC);
        check_eq("t6_wdata_rst", wdata_ls, 32'd0);
        dren = 0;
        step();
        nRST = 1'b1;
        dmem_busy  = 0;
        dmem_rdata = 32'h8001_0000;
        set_req(32'h7000, 32'h2, 3'b001, 1, 0, 1, 5'd9);
        step();
        check_eq("t6_lh_ren", {31'd0, dmem_ren}, 32'd1);
        check_eq("t6_lh_be", {28'd0, dmem_byte_en}, 32'hC);
        check_eq("t6_lh_addr", dmem_addr, 32'h7000);
        step();
        dren = 0;
        #1;
        check_eq("t6_lh_wen_out", {31'd0, wen_out}, 32'd1);
        check_eq("t6_lh_data", wdata_ls, 32'hFFFF8001);
        check_eq("t6_lh_rd", {27'd0, reg_rd_out}, 32'd9);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
